// File: rtl/bp_pkg.sv
// Shared types, counter encodings and the saturating-counter update for the gshare predictor.
package bp_pkg;

    typedef logic [1:0] bp_ctr_t;

    localparam bp_ctr_t CTR_SNT    = 2'd0;
    localparam bp_ctr_t CTR_WNT    = 2'd1;
    localparam bp_ctr_t CTR_WT     = 2'd2;
    localparam bp_ctr_t CTR_ST     = 2'd3;
    localparam int      BP_INDEX_W = 8;

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } bp_state_e;

    // Two-bit saturating counter step; never wraps at either end.
    function automatic bp_ctr_t bp_ctr_next(bp_ctr_t c, logic taken);
        bp_ctr_t n;
        n = c;
        if (taken) begin
            if (c != CTR_ST) n = c + 2'd1;
        end else begin
            if (c != CTR_SNT) n = c - 2'd1;
        end
        return n;
    endfunction

endpackage

// File: rtl/gshare_pht.sv
// Pattern history table: registered query read with write-first bypass,
// asynchronous read for the training read-modify-write, single write port.
module gshare_pht
    import bp_pkg::*;
#(
    parameter int INDEX_W = BP_INDEX_W
) (
    input  logic               clk,
    input  logic [INDEX_W-1:0] rd_idx,
    output bp_ctr_t            rd_data,
    input  logic [INDEX_W-1:0] upd_rd_idx,
    output bp_ctr_t            upd_rd_data,
    input  logic               we,
    input  logic [INDEX_W-1:0] wr_idx,
    input  bp_ctr_t            wr_data
);

    bp_ctr_t mem [0:(2**INDEX_W)-1];
    bp_ctr_t rd_data_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_idx] <= wr_data;
        end
        // Same-cycle write to the queried entry must be visible in the registered read.
        if (we && (wr_idx == rd_idx)) begin
            rd_data_q <= wr_data;
        end else begin
            rd_data_q <= mem[rd_idx];
        end
    end

    assign rd_data     = rd_data_q;
    assign upd_rd_data = mem[upd_rd_idx];

endmodule

// File: rtl/gshare_predictor.sv
// Gshare direction predictor: init FSM, global history, PHT training mux.
// Define BRANCH_PRED_STATS_EN to add the resolved-branch / mispredict counters.
module gshare_predictor
    import bp_pkg::*;
#(
    parameter int INDEX_W = BP_INDEX_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        query_pc,
    output logic [INDEX_W-1:0] pc_xor_global_history,
    output logic               prediction,
    output logic               ready,
    input  logic               upd_valid,
    input  logic [INDEX_W-1:0] upd_index,
    input  logic               upd_taken,
    input  logic               upd_mispredict
`ifdef BRANCH_PRED_STATS_EN
    ,
    output logic [31:0]        stat_branches,
    output logic [31:0]        stat_mispredicts
`endif
);

    bp_state_e          state_q, state_d;
    logic [INDEX_W-1:0] init_idx_q, init_idx_d;
    logic [INDEX_W-1:0] ghr_q, ghr_d;
    logic               pred_en_q;
    logic               pht_we;
    logic [INDEX_W-1:0] pht_wr_idx;
    bp_ctr_t            pht_wr_data;
    bp_ctr_t            pht_rd_data;
    bp_ctr_t            pht_upd_data;
    logic               train;
    logic               unused_bits;

    assign pc_xor_global_history = query_pc[INDEX_W+1:2] ^ ghr_q;
    assign train                 = (state_q == ST_READY) && upd_valid;
    assign ready                 = (state_q == ST_READY);
    // The read register is not reset, so the enable keeps prediction low through reset/init.
    assign prediction            = pred_en_q & pht_rd_data[1];

    always_comb begin
        state_d     = state_q;
        init_idx_d  = init_idx_q;
        ghr_d       = ghr_q;
        pht_we      = 1'b0;
        pht_wr_idx  = upd_index;
        pht_wr_data = bp_ctr_next(pht_upd_data, upd_taken);
        case (state_q)
            ST_INIT: begin
                pht_we      = 1'b1;
                pht_wr_idx  = init_idx_q;
                pht_wr_data = CTR_WNT;
                init_idx_d  = init_idx_q + 1'b1;
                if (&init_idx_q) state_d = ST_READY;
            end
            ST_READY: begin
                if (upd_valid) begin
                    pht_we = 1'b1;
                    ghr_d  = {ghr_q[INDEX_W-2:0], upd_taken};
                end
            end
            default: state_d = ST_INIT;
        endcase
        if (rst) pht_we = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_INIT;
            init_idx_q <= '0;
            ghr_q      <= '0;
            pred_en_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            init_idx_q <= init_idx_d;
            ghr_q      <= ghr_d;
            pred_en_q  <= (state_q == ST_READY);
        end
    end

    gshare_pht #(
        .INDEX_W (INDEX_W)
    ) u_pht (
        .clk         (clk),
        .rd_idx      (pc_xor_global_history),
        .rd_data     (pht_rd_data),
        .upd_rd_idx  (upd_index),
        .upd_rd_data (pht_upd_data),
        .we          (pht_we),
        .wr_idx      (pht_wr_idx),
        .wr_data     (pht_wr_data)
    );

`ifdef BRANCH_PRED_STATS_EN
    logic [31:0] stat_br_q, stat_mp_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_br_q <= '0;
            stat_mp_q <= '0;
        end else if (train) begin
            stat_br_q <= stat_br_q + 32'd1;
            if (upd_mispredict) stat_mp_q <= stat_mp_q + 32'd1;
        end
    end

    assign stat_branches    = stat_br_q;
    assign stat_mispredicts = stat_mp_q;
    assign unused_bits      = ^{query_pc[31:INDEX_W+2], query_pc[1:0]};
`else
    assign unused_bits      = ^{query_pc[31:INDEX_W+2], query_pc[1:0], upd_mispredict, train};
`endif

endmodule
